// File: rtl/beta_pkg.sv
// Shared Beta pipeline definitions: IR mux select codes, fixed instruction
// words injected by the pipeline, memory opcodes and the memory-stage FSM
// state type.
package beta_pkg;

    // ir_src_mem encodings
    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_NOP    = 2'd1;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

    // Memory opcodes (ir[31:26])
    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_LDR = 6'h1F;

    // ADDC(R31, 0, R31)
    localparam logic [31:0] INST_NOP        = 32'hC3FF_0000;
    // BNE(R31, 0, XP): saves the faulting PC in XP
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_0000;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT_RSP
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus a response channel.
//   master (memory stage): drives dmem_req_valid, dmem_we, dmem_addr, dmem_wdata
//   slave  (memory):       drives dmem_req_ready, dmem_rsp_valid, dmem_rdata
interface mem_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_timeout.sv
// Stall timeout counter for the memory stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   stall      : count this cycle (otherwise the counter clears)
//   clear      : force the counter back to zero
//   expired    : counter has reached TIMEOUT_CYCLES (never when it is 0)
module mem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clear,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !stall) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_stage.sv
// Beta memory stage: registers the execute-stage outputs, issues LD/LDR reads
// and ST writes on the data-memory port, stalls upstream while an access is
// outstanding and turns an access timeout into an exception instruction.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ir_src_mem            : IR mux select for the instruction in this stage
//   mem_rd_next/wr_next   : next instruction is a load / store
//   *_mem_next            : pc/ir/y/st from execute
//   dmem                  : data-memory port (master side)
//   *_wb_next             : values for the writeback registers
//   stall_mem             : hold all upstream registers
//   mem_fault             : one-cycle pulse on access timeout
module mem_stage
    import beta_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ir_src_mem,
    input  logic              mem_rd_next,
    input  logic              mem_wr_next,
    input  logic [31:0]       pc_mem_next,
    input  logic [31:0]       ir_mem_next,
    input  logic [31:0]       y_mem_next,
    input  logic [31:0]       st_mem_next,
    mem_stage_if.master       dmem,
    output logic [31:0]       pc_wb_next,
    output logic [31:0]       ir_wb_next,
    output logic [31:0]       y_wb_next,
    output logic [31:0]       rdata_wb_next,
    output logic              stall_mem,
    output logic              mem_fault
);

    logic [31:0] pc, ir, y, st;
    logic        rd, wr;
    mem_state_e  state, state_next;
    logic        access, stall_raw, rsp_take, expired;

    // Stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= INST_NOP;
            y  <= '0;
            st <= '0;
            rd <= 1'b0;
            wr <= 1'b0;
        end else if (!stall_mem) begin
            pc <= pc_mem_next;
            ir <= ir_mem_next;
            y  <= y_mem_next;
            st <= st_mem_next;
            rd <= mem_rd_next;
            wr <= mem_wr_next;
        end
    end

    // Annulled instructions never reach memory
    assign access = (rd || wr) && (ir_src_mem == IR_SRC_DATA);

    assign dmem.dmem_addr  = {y[31:2], 2'b00};
    assign dmem.dmem_we    = wr;
    assign dmem.dmem_wdata = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        dmem.dmem_req_valid = 1'b0;
        stall_raw           = 1'b0;
        rsp_take            = 1'b0;
        case (state)
            MEM_IDLE: begin
                dmem.dmem_req_valid = access;
                if (access) begin
                    if (dmem.dmem_req_ready) begin
                        // accepted stores complete without stalling
                        if (rd) begin
                            state_next = MEM_WAIT_RSP;
                            stall_raw  = 1'b1;
                        end
                    end else begin
                        stall_raw = 1'b1;
                    end
                end
            end
            MEM_WAIT_RSP: begin
                if (dmem.dmem_rsp_valid) begin
                    rsp_take   = 1'b1;
                    state_next = MEM_IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
        // Timeout abandons the access and releases the pipeline
        if (expired) begin
            state_next = MEM_IDLE;
        end
    end

    assign stall_mem     = stall_raw && !expired;
    assign mem_fault     = expired;
    assign rdata_wb_next = (rsp_take && !expired) ? dmem.dmem_rdata : '0;

    mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (stall_mem),
        .clear  (mem_fault),
        .expired(expired)
    );

    always_comb begin
        if (expired) begin
            ir_wb_next = INST_BNE_EXCEPT;
        end else begin
            case (ir_src_mem)
                IR_SRC_DATA:   ir_wb_next = ir;
                IR_SRC_NOP:    ir_wb_next = INST_NOP;
                IR_SRC_EXCEPT: ir_wb_next = INST_BNE_EXCEPT;
                default:       ir_wb_next = 'x;
            endcase
        end
    end

    assign pc_wb_next = pc;
    assign y_wb_next  = y;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage with a scripted data-memory responder.
module tb_mem_stage;
    import beta_pkg::*;

    localparam int unsigned TO            = 8;
    localparam logic [31:0] RSP_IDLE_DATA = 32'hBAD0_BAD0;
    localparam logic [31:0] I_ADD = 32'h8022_1800;
    localparam logic [31:0] I_LD  = {OP_LD,  5'd4, 5'd31, 16'h0000};
    localparam logic [31:0] I_LDR = {OP_LDR, 5'd5, 5'd31, 16'h0000};
    localparam logic [31:0] I_ST  = {OP_ST,  5'd6, 5'd31, 16'h0000};

    logic        clk, rst_n;
    logic [1:0]  ir_src_mem;
    logic        mem_rd_next, mem_wr_next;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next, rdata_wb_next;
    logic        stall_mem, mem_fault;

    mem_stage_if dmem();

    mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_src_mem   (ir_src_mem),
        .mem_rd_next  (mem_rd_next),
        .mem_wr_next  (mem_wr_next),
        .pc_mem_next  (pc_mem_next),
        .ir_mem_next  (ir_mem_next),
        .y_mem_next   (y_mem_next),
        .st_mem_next  (st_mem_next),
        .dmem         (dmem),
        .pc_wb_next   (pc_wb_next),
        .ir_wb_next   (ir_wb_next),
        .y_wb_next    (y_wb_next),
        .rdata_wb_next(rdata_wb_next),
        .stall_mem    (stall_mem),
        .mem_fault    (mem_fault)
    );

    typedef struct {
        logic [31:0] pc, ir, y, rdata;
        logic        fault;
        int unsigned req_cyc, stall_cyc;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_cmp = 0, n_err = 0;

    // Configuration of the instruction currently in the stage
    int unsigned c_rdy = 0, c_lat = 0;
    logic [31:0] c_addr = '0, c_wdata = '0, c_rsp = '0;
    logic        c_we = 1'b0;
    logic [1:0]  c_src2 = IR_SRC_DATA;
    bit          c_hs = 0;
    int unsigned stall_cnt = 0, req_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic finish_sim;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    function automatic logic [31:0] ir_sel(input logic [1:0] src, input logic [31:0] ir);
        case (src)
            IR_SRC_NOP:    return INST_NOP;
            IR_SRC_EXCEPT: return INST_BNE_EXCEPT;
            default:       return ir;
        endcase
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e.pc = '0; e.ir = INST_NOP; e.y = '0; e.rdata = '0;
        e.fault = 1'b0; e.req_cyc = 0; e.stall_cyc = 0;
        return e;
    endfunction

    // Called at negedge+1: request checks, and scoreboard pop when the stage releases
    task automatic monitor_cycle(output bit free);
        exp_t e;
        if (dmem.dmem_req_valid) begin
            req_cnt++;
            check("req_addr",  dmem.dmem_addr, c_addr);
            check("req_we",    32'(dmem.dmem_we), 32'(c_we));
            check("req_wdata", dmem.dmem_wdata, c_wdata);
        end
        free = !stall_mem;
        if (stall_mem) begin
            stall_cnt++;
            check("rdata_stall", rdata_wb_next, 32'h0);
            check("fault_stall", 32'(mem_fault), 32'h0);
        end else if (exp_q.size() == 0) begin
            check("queue_nonempty", 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            check("pc_wb",       pc_wb_next, e.pc);
            check("ir_wb",       ir_wb_next, e.ir);
            check("y_wb",        y_wb_next, e.y);
            check("rdata_wb",    rdata_wb_next, e.rdata);
            check("mem_fault",   32'(mem_fault), 32'(e.fault));
            check("req_cycles",  req_cnt, e.req_cyc);
            check("stall_cycles", stall_cnt, e.stall_cyc);
        end
        if (c_hs) ir_src_mem = c_src2;
        if (dmem.dmem_req_valid && dmem.dmem_req_ready && !dmem.dmem_we) c_hs = 1;
    endtask

    // Present one instruction at a negedge; returns at the negedge after it enters the stage.
    // src2 replaces ir_src_mem once a read has been accepted.
    task automatic send(input logic [31:0] pc, ir, y, st, input logic rd, wr,
                        input logic [1:0] src, src2, input int unsigned rdy, lat,
                        input logic [31:0] rsp);
        bit free;
        int unsigned guard, nominal;
        exp_t e;
        pc_mem_next = pc; ir_mem_next = ir; y_mem_next = y; st_mem_next = st;
        mem_rd_next = rd; mem_wr_next = wr;
        free = 0;
        guard = 0;
        while (!free) begin
            #1;
            monitor_cycle(free);
            if (!free) begin
                guard++;
                if (guard > 100) begin
                    check("load_timeout", guard, 32'h0);
                    finish_sim();
                end
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        ir_src_mem = src;
        c_src2 = src2; c_rdy = rdy; c_lat = lat; c_rsp = rsp;
        c_addr = {y[31:2], 2'b00}; c_we = wr; c_wdata = st;
        c_hs = 0; stall_cnt = 0; req_cnt = 0;
        e.pc = pc; e.y = y; e.rdata = '0; e.fault = 1'b0;
        e.req_cyc = 0; e.stall_cyc = 0;
        e.ir = ir_sel(src2, ir);
        if ((rd || wr) && src == IR_SRC_DATA) begin
            nominal = rd ? rdy + 1 + lat : rdy;
            if (nominal >= TO) begin
                e.fault = 1'b1;
                e.ir = INST_BNE_EXCEPT;
                e.stall_cyc = TO;
                e.req_cyc = (rdy < TO) ? rdy + 1 : TO + 1;
            end else begin
                e.stall_cyc = nominal;
                e.req_cyc = rdy + 1;
                if (rd) e.rdata = rsp;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] pc, ir, y, st, input logic rd, wr,
                         input logic [1:0] src, input int unsigned rdy, lat,
                         input logic [31:0] rsp);
        send(pc, ir, y, st, rd, wr, src, src, rdy, lat, rsp);
    endtask

    // Memory model: ready after c_rdy refused cycles, response c_lat cycles after the first WAIT cycle
    initial begin
        int unsigned rw, cd;
        logic [31:0] held;
        rw = 0; cd = 0; held = '0;
        dmem.dmem_req_ready = 1'b1;
        dmem.dmem_rsp_valid = 1'b0;
        dmem.dmem_rdata = RSP_IDLE_DATA;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                rw = 0; cd = 0;
            end else if (dmem.dmem_req_valid) begin
                if (dmem.dmem_req_ready) begin
                    rw = 0;
                    if (!dmem.dmem_we) begin
                        cd = c_lat + 1;
                        held = c_rsp;
                    end
                end else begin
                    rw++;
                end
            end
            @(posedge clk);
            #2;
            dmem.dmem_rsp_valid = 1'b0;
            dmem.dmem_rdata = RSP_IDLE_DATA;
            if (!rst_n) begin
                rw = 0; cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dmem.dmem_rsp_valid = 1'b1;
                    dmem.dmem_rdata = held;
                end
            end
            dmem.dmem_req_ready = (rw >= c_rdy);
        end
    end

    initial begin
        bit free;
        rst_n = 1'b0;
        ir_src_mem = IR_SRC_DATA;
        mem_rd_next = 1'b0; mem_wr_next = 1'b0;
        pc_mem_next = '0; ir_mem_next = INST_NOP; y_mem_next = '0; st_mem_next = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(dmem.dmem_req_valid), 32'h0);
        check("rst_stall",     32'(stall_mem), 32'h0);
        check("rst_fault",     32'(mem_fault), 32'h0);
        check("rst_rdata",     rdata_wb_next, 32'h0);
        check("rst_ir",        ir_wb_next, INST_NOP);
        check("rst_pc",        pc_wb_next, 32'h0);
        #2 rst_n = 1'b1;
        exp_q.push_back(reset_entry());
        @(negedge clk);

        issue(32'h104, I_ADD, 32'h10,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h108, I_ST,  32'h1236, 32'hDEADBEEF, 0, 1, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h10C, I_LD,  32'h40,   32'h0,        1, 0, IR_SRC_DATA,   3, 2, 32'hCAFEF00D);
        issue(32'h110, I_LD,  32'h44,   32'h0,        1, 0, IR_SRC_NOP,    0, 0, 32'h0000_0001);
        issue(32'h114, I_ADD, 32'h18,   32'h0,        0, 0, IR_SRC_EXCEPT, 0, 0, 32'h0);
        send (32'h118, I_LD,  32'h80,   32'h0,        1, 0, IR_SRC_DATA, IR_SRC_EXCEPT, 0, 2, 32'h1234_5678);
        issue(32'h11C, I_LDR, 32'h84,   32'h0,        1, 0, IR_SRC_DATA,   0, 0, 32'h1111_0000);
        issue(32'h120, I_LD,  32'h89,   32'h0,        1, 0, IR_SRC_DATA,   1, 0, 32'h2222_0000);
        issue(32'h124, I_LD,  32'hA0,   32'h0,        1, 0, IR_SRC_DATA,   2, 4, 32'h7777_0001);
        issue(32'h128, I_LD,  32'hA4,   32'h0,        1, 0, IR_SRC_DATA,   0, 7, 32'h8888_0002);
        issue(32'h12C, I_ADD, 32'h20,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h130, I_LD,  32'hA8,   32'h0,        1, 0, IR_SRC_DATA,   0, 9, 32'h9999_0003);
        issue(32'h134, I_ADD, 32'h24,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h138, I_ADD, 32'h28,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h13C, I_ADD, 32'h2C,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h140, I_ST,  32'h200,  32'h0BADF00D, 0, 1, IR_SRC_DATA,   2, 0, 32'h0);
        issue(32'h144, I_LD,  32'h100,  32'h0,        1, 0, IR_SRC_DATA,   0, 5, 32'h5555_0004);

        // LD at 0x144 is in its accept cycle; reset it from WAIT_RSP
        #1;
        check("pre_rst_req",   32'(dmem.dmem_req_valid), 32'h1);
        @(negedge clk);
        #1;
        check("pre_rst_stall", 32'(stall_mem), 32'h1);
        check("pre_rst_valid", 32'(dmem.dmem_req_valid), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", 32'(dmem.dmem_req_valid), 32'h0);
        check("mid_rst_stall",     32'(stall_mem), 32'h0);
        check("mid_rst_fault",     32'(mem_fault), 32'h0);
        check("mid_rst_rdata",     rdata_wb_next, 32'h0);
        check("mid_rst_ir",        ir_wb_next, INST_NOP);
        check("mid_rst_pc",        pc_wb_next, 32'h0);
        pc_mem_next = '0; ir_mem_next = INST_NOP; y_mem_next = '0; st_mem_next = '0;
        mem_rd_next = 1'b0; mem_wr_next = 1'b0;
        ir_src_mem = IR_SRC_DATA;
        exp_q.delete();
        c_rdy = 0; c_hs = 0; c_src2 = IR_SRC_DATA; stall_cnt = 0; req_cnt = 0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        exp_q.push_back(reset_entry());
        @(negedge clk);

        issue(32'h200, I_LD,  32'h300,  32'h0,        1, 0, IR_SRC_DATA,   0, 1, 32'hFEED_0005);
        issue(32'h204, I_ADD, 32'h30,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        issue(32'h208, I_ADD, 32'h34,   32'h0,        0, 0, IR_SRC_DATA,   0, 0, 32'h0);
        #1;
        monitor_cycle(free);
        check("queue_drained", exp_q.size(), 32'h0);
        finish_sim();
    end

endmodule
